// File: rtl/avk_capacitance_mc.sv
// Multi-channel capacitance sensor front end: each channel times how long the
// sensed node takes to cross a threshold, alternating charge and discharge.

module avk_cap_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clock,
  input  logic pos_reset,
  input  logic i_raw,
  output logic o_filt
);
  localparam int FILT_W = $clog2(FILT_LEN + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_filt;
  logic [FILT_W-1:0] r_run;

  // r_run counts consecutive cycles the synchronized value disagrees with r_filt
  always_ff @(posedge clock or posedge pos_reset) begin
    if (pos_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_run   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_run <= '0;
      end else if (r_run == FILT_LAST) begin
        r_filt <= r_sync2;
        r_run  <= '0;
      end else begin
        r_run <= r_run + FILT_W'(1);
      end
    end
  end

  assign o_filt = r_filt;
endmodule

module avk_capacitance_mc #(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 16,
  parameter int FILT_LEN  = 4,
  parameter int DWELL_CNT = 20000,
  parameter int TIMEOUT   = (1 << CNT_W) - 1
) (
  input  logic                      clock,
  input  logic                      pos_reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       pos_comparator,
  input  logic [CHANNELS-1:0]       neg_comparator,
  output logic [CHANNELS-1:0]       reference,
  output logic [CHANNELS*CNT_W-1:0] result,
  output logic [CHANNELS-1:0]       result_valid,
  output logic [CHANNELS-1:0]       timeout,
  output logic [CHANNELS-1:0]       busy
);
  localparam int DWELL_W = (DWELL_CNT > 1) ? $clog2(DWELL_CNT) : 1;
  localparam logic [CNT_W-1:0]   TIMEOUT_V  = CNT_W'(TIMEOUT);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CNT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CHARGE, ST_DWELL} state_t;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_result;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_ref;
    logic               r_valid;
    logic               r_tmo;
    logic               w_pos_f;
    logic               w_neg_f;
    logic               w_cross;

    avk_cap_filter #(.FILT_LEN(FILT_LEN)) u_pos_filt (
      .clock(clock), .pos_reset(pos_reset), .i_raw(pos_comparator[gi]), .o_filt(w_pos_f)
    );
    avk_cap_filter #(.FILT_LEN(FILT_LEN)) u_neg_filt (
      .clock(clock), .pos_reset(pos_reset), .i_raw(neg_comparator[gi]), .o_filt(w_neg_f)
    );

    // Only the comparator facing the current charge direction can end a measurement
    assign w_cross = r_ref ? w_pos_f : w_neg_f;

    always_ff @(posedge clock or posedge pos_reset) begin
      if (pos_reset) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_result <= '0;
        r_dwell  <= '0;
        r_ref    <= 1'b0;
        r_valid  <= 1'b0;
        r_tmo    <= 1'b0;
      end else begin
        r_valid <= 1'b0;
        if (!enable[gi]) begin
          r_state <= ST_IDLE;
          r_ref   <= 1'b0;
          r_cnt   <= '0;
          r_dwell <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              r_state <= ST_CHARGE;
              r_ref   <= 1'b1;
              r_cnt   <= '0;
              r_dwell <= '0;
            end
            ST_CHARGE: begin
              // A crossing on the limit cycle still counts as a real crossing
              if (w_cross) begin
                r_result <= r_cnt;
                r_tmo    <= 1'b0;
                r_valid  <= 1'b1;
                r_state  <= ST_DWELL;
                r_dwell  <= '0;
              end else if (r_cnt == TIMEOUT_V) begin
                r_result <= TIMEOUT_V;
                r_tmo    <= 1'b1;
                r_valid  <= 1'b1;
                r_state  <= ST_DWELL;
                r_dwell  <= '0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            ST_DWELL: begin
              if (r_dwell == DWELL_LAST) begin
                r_ref   <= ~r_ref;
                r_state <= ST_CHARGE;
                r_cnt   <= '0;
                r_dwell <= '0;
              end else begin
                r_dwell <= r_dwell + DWELL_W'(1);
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end

    assign reference[gi]                 = r_ref;
    assign result[gi*CNT_W +: CNT_W]     = r_result;
    assign result_valid[gi]              = r_valid;
    assign timeout[gi]                   = r_tmo;
    assign busy[gi]                      = (r_state != ST_IDLE);
  end
endmodule

// File: tb/tb_avk_capacitance_mc.sv
// Bench for avk_capacitance_mc: channel 0 runs randomized measurements against
// an arithmetic model; channel 1 free-runs into timeouts and is dropped mid-charge.

module tb_avk_capacitance_mc;
  localparam int CH     = 2;
  localparam int CW     = 8;
  localparam int FL     = 2;
  localparam int DW     = 4;
  localparam int TO     = 50;
  localparam int LAT    = 2 + FL;
  localparam int PERIOD = TO + 1 + DW;

  logic             clock = 1'b0;
  logic             pos_reset;
  logic [CH-1:0]    enable;
  logic [CH-1:0]    pos_comparator;
  logic [CH-1:0]    neg_comparator;
  logic [CH-1:0]    reference;
  logic [CH*CW-1:0] result;
  logic [CH-1:0]    result_valid;
  logic [CH-1:0]    timeout;
  logic [CH-1:0]    busy;

  int total = 0;
  int bad   = 0;

  // Channel 1 expectation state: m1 = cycles since its first CHARGE cycle, -1 = idle
  int          m1 = -1;
  bit          pend1 = 1'b0;
  bit          drop1 = 1'b0;
  logic [CW-1:0] res1_exp = '0;
  logic        tmo1_exp = 1'b0;
  logic        r0;

  always #5 clock = ~clock;

  avk_capacitance_mc #(
    .CHANNELS(CH), .CNT_W(CW), .FILT_LEN(FL), .DWELL_CNT(DW), .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .pos_reset(pos_reset),
    .enable(enable),
    .pos_comparator(pos_comparator),
    .neg_comparator(neg_comparator),
    .reference(reference),
    .result(result),
    .result_valid(result_valid),
    .timeout(timeout),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_reference"}, 32'(reference), 32'(0));
    chk({tag, "_result"}, 32'(result), 32'(0));
    chk({tag, "_valid"}, 32'(result_valid), 32'(0));
    chk({tag, "_timeout"}, 32'(timeout), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  // Called once per cycle at the falling edge; also schedules channel 1 for the next cycle.
  task automatic tick1();
    int   ph;
    logic rexp;
    ph = (m1 >= 0) ? (m1 % PERIOD) : 0;
    if (m1 < 0) begin
      chk("ch1_idle_busy", 32'(busy[1]), 32'(0));
      chk("ch1_idle_ref", 32'(reference[1]), 32'(0));
      chk("ch1_idle_valid", 32'(result_valid[1]), 32'(0));
    end else begin
      rexp = ((m1 / PERIOD) % 2) == 0;
      chk("ch1_busy", 32'(busy[1]), 32'(1));
      chk("ch1_ref", 32'(reference[1]), 32'(rexp));
      chk("ch1_valid", 32'(result_valid[1]), 32'(ph == TO + 1));
      if (ph == TO + 1) begin
        res1_exp = CW'(TO);
        tmo1_exp = 1'b1;
      end
    end
    chk("ch1_result", 32'(result[2*CW-1:CW]), 32'(res1_exp));
    chk("ch1_timeout", 32'(timeout[1]), 32'(tmo1_exp));
    if (drop1 && m1 >= PERIOD + 5 && ph >= 5 && ph <= 40) begin
      enable[1] = 1'b0;
      m1 = -1;
      drop1 = 1'b0;
    end else if (pend1) begin
      m1 = 0;
      pend1 = 1'b0;
    end else if (m1 >= 0) begin
      m1++;
    end
  endtask

  // One channel-0 measurement starting in its first CHARGE cycle. The facing
  // comparator goes high at cycle d (held through the end of CHARGE); g places a
  // one-cycle glitch; the ignored comparator carries random noise.
  task automatic measure0(input logic ref_e, input int d, input int g, input bit stop_in_dwell);
    int   c;
    logic tmo_e;
    logic act;
    logic noise;
    if (d + LAT <= TO) begin
      c = d + LAT;
      tmo_e = 1'b0;
    end else begin
      c = TO;
      tmo_e = 1'b1;
    end
    for (int k = 0; k <= c + DW; k++) begin
      act   = ((k >= d) || (k == g)) && (k <= c);
      noise = (k <= c) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ref_e) begin
        pos_comparator[0] = act;
        neg_comparator[0] = noise;
      end else begin
        neg_comparator[0] = act;
        pos_comparator[0] = noise;
      end
      @(negedge clock);
      chk("ch0_ref", 32'(reference[0]), 32'(ref_e));
      chk("ch0_busy", 32'(busy[0]), 32'(1));
      chk("ch0_valid", 32'(result_valid[0]), 32'(k == c + 1));
      if (k == c + 1) begin
        chk("ch0_result", 32'(result[CW-1:0]), 32'(c));
        chk("ch0_timeout", 32'(timeout[0]), 32'(tmo_e));
      end
      tick1();
      if (stop_in_dwell && k == c + 2) return;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic release_and_start();
    pos_reset = 1'b0;
    enable = 2'b01;
    @(negedge clock);
    chk("ch0_pre_busy", 32'(busy[0]), 32'(0));
    chk("ch0_pre_ref", 32'(reference[0]), 32'(0));
    tick1();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int sel;
    pos_reset = 1'b1;
    enable = '0;
    pos_comparator = '0;
    neg_comparator = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("rst");
    @(posedge clock);
    #1;
    release_and_start();

    r0 = 1'b1;
    measure0(r0, 10, -1, 1'b0);
    r0 = ~r0;
    enable[1] = 1'b1;
    pend1 = 1'b1;
    drop1 = 1'b1;
    measure0(r0, 255, -1, 1'b0);
    r0 = ~r0;
    measure0(r0, TO - LAT, -1, 1'b0);
    r0 = ~r0;
    measure0(r0, 255, 20, 1'b0);
    r0 = ~r0;

    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0) measure0(r0, int'($urandom_range(0, TO - LAT)), -1, 1'b0);
      else if (sel == 1) measure0(r0, int'($urandom_range(TO - LAT + 1, 70)), -1, 1'b0);
      else measure0(r0, 255, int'($urandom_range(0, TO)), 1'b0);
      r0 = ~r0;
    end

    measure0(r0, int'($urandom_range(0, 40)), -1, 1'b1);
    pos_reset = 1'b1;
    #1;
    check_all_zero("rst_dwell");
    enable = '0;
    pos_comparator = '0;
    neg_comparator = '0;
    m1 = -1;
    pend1 = 1'b0;
    drop1 = 1'b0;
    res1_exp = '0;
    tmo1_exp = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    release_and_start();
    measure0(1'b1, 10, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/avk_capacitance_mc.md
AVK_CAPACITANCE_MC -- requirements
Module: avk_capacitance_mc

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent measurement channels (>=1).
REQ-002 Parameter CNT_W, default 16: width of the charge-time counter and result per channel.
REQ-003 Parameter FILT_LEN, default 4: consecutive stable cycles required by the comparator glitch filter (>=1).
REQ-004 Parameter DWELL_CNT, default 20000: dwell cycles before reference toggle (5 ms at 4 MHz), >=1.
REQ-005 Parameter TIMEOUT, default 2^CNT_W-1: charge-count limit, <= 2^CNT_W-1.
REQ-006 clock  in  1  system clock, 4 MHz nominal; all logic on rising edge.
REQ-007 pos_reset  in  1  asynchronous, active-high reset.
REQ-008 enable  in  CHANNELS  per-channel run enable, synchronous level.
REQ-009 pos_comparator  in  CHANNELS  asynchronous; 1 = voltage above upper threshold.
REQ-010 neg_comparator  in  CHANNELS  asynchronous; 1 = voltage below lower threshold.
REQ-011 reference  out  CHANNELS  charge direction, 1 = charge up, 0 = discharge; registered.
REQ-012 result  out  CHANNELS*CNT_W  last charge time of channel i in bits [i*CNT_W +: CNT_W].
REQ-013 result_valid  out  CHANNELS  one-cycle pulse when result[i] updates.
REQ-014 timeout  out  CHANNELS  1 = last result of channel i was a timeout.
REQ-015 busy  out  CHANNELS  1 = channel i not in IDLE.

Function
REQ-016 Each comparator input SHALL pass a 2-flop synchronizer, then a filter whose output changes only after the synchronized value differs from it for FILT_LEN consecutive cycles; input-to-filtered latency SHALL be 2+FILT_LEN cycles.
REQ-017 Each channel SHALL run an independent FSM: IDLE, CHARGE, DWELL; channels share no state.
REQ-018 IDLE: reference=0, busy=0, counters held 0; enable=1 -> CHARGE next cycle with reference set to 1.
REQ-019 CHARGE: charge counter SHALL be 0 on the first CHARGE cycle and increment by 1 each cycle without crossing.
REQ-020 Crossing SHALL be filtered pos=1 when reference=1, filtered neg=1 when reference=0; the other comparator SHALL be ignored.
REQ-021 On crossing: result<=counter value that cycle, timeout<=0, result_valid=1 the following cycle, state -> DWELL.
REQ-022 If counter==TIMEOUT without crossing: result<=TIMEOUT, timeout<=1, result_valid pulse, -> DWELL; counter SHALL never wrap.
REQ-023 Crossing and counter==TIMEOUT in the same cycle: crossing wins, timeout<=0.
REQ-024 DWELL: dwell counter counts 0..DWELL_CNT-1; on the last count reference SHALL invert and state -> CHARGE with charge counter 0.
REQ-025 reference SHALL change only on DWELL exit, IDLE entry (->0) or IDLE exit (->1).
REQ-026 enable=0 in any state: -> IDLE next cycle, reference=0, counters cleared, no result_valid; result and timeout hold last values.
REQ-027 A filter that is already 1 on CHARGE entry SHALL count as crossing on the first CHARGE cycle (result=0).

Reset
REQ-028 pos_reset=1 SHALL immediately force all channels IDLE, reference=0, result=0, result_valid=0, timeout=0, busy=0, synchronizers, filters and counters 0.
REQ-029 After pos_reset falls, a channel with enable=1 SHALL enter CHARGE on the second rising edge at the latest.

Verification (CHANNELS=2, CNT_W=8, FILT_LEN=2, DWELL_CNT=4, TIMEOUT=50)
REQ-030 enable[0]=1, pos_comparator[0] rises 10 cycles after CHARGE entry -> result[7:0]=14, one result_valid[0] pulse, timeout[0]=0, reference[0] falls 4 cycles later.
REQ-031 No comparator activity -> result[7:0]=50, timeout[0]=1, reference toggles every 55 cycles, counter never exceeds 50.
REQ-032 One-cycle pos_comparator glitch during CHARGE -> no crossing, count continues to timeout=50.
REQ-033 enable[1] dropped mid-CHARGE -> reference[1]=0 and busy[1]=0 next cycle, no result_valid[1], result[15:8] unchanged; channel 0 unaffected.
REQ-034 pos_reset pulsed mid-DWELL on both channels -> all outputs 0 immediately; re-enable yields first result identical to REQ-030.
REQ-035 Filtered crossing on cycle where counter==50 -> result=50, timeout=0.
